// File: rtl/sub128_pkg.sv
// Shared constants and state encoding for the serial 128-bit subtractor.
package sub128_pkg;

    localparam int N      = 128;
    localparam int W      = 32;
    localparam int NSLICE = N / W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub128_serial_sub_slice.sv
// Combinational W-bit slice subtract: d = a - b - bin, computed as a lookahead
// add of a, ~b and ~bin so it shares structure with the adder slices.
module sub_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    always_comb begin
        c[0] = ~bin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign d    = p ^ c[W-1:0];
    assign bout = ~c[W];

endmodule

// File: rtl/sub128_serial.sv
// Multi-cycle N-bit subtractor, one W-bit slice per clock, LSB first.
// Optional flag outputs (zero/ovf/lt_s) enabled by SUB128_SERIAL_FLAGS_EN.
module sub128_serial
    import sub128_pkg::*;
#(
    parameter int N = sub128_pkg::N,
    parameter int W = sub128_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SUB128_SERIAL_FLAGS_EN
    ,
    output logic         zero,
    output logic         ovf,
    output logic         lt_s
`endif
);

    localparam int NSLICE = N / W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    diff_q, diff_d;

    logic [W-1:0]    sl_a, sl_b, sl_d;
    logic            sl_bout;
    logic            last;

`ifdef SUB128_SERIAL_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
    logic lt_q, lt_d;
`endif

    assign sl_a = a_q[idx_q*W +: W];
    assign sl_b = b_q[idx_q*W +: W];
    assign last = (idx_q == IDXW'(NSLICE - 1));

    sub_slice #(.W(W)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (borrow_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SUB128_SERIAL_FLAGS_EN
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        lt_d      = lt_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = RUN;
`ifdef SUB128_SERIAL_FLAGS_EN
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    lt_d     = 1'b0;
`endif
                end
            end
            RUN: begin
                diff_d[idx_q*W +: W] = sl_d;
                borrow_d             = sl_bout;
                idx_d                = idx_q + 1'b1;
`ifdef SUB128_SERIAL_FLAGS_EN
                // Zero accumulates per slice; sign flags only matter on the top slice.
                zero_d = zero_q & ~(|sl_d);
                if (last) begin
                    ovf_d = (a_q[N-1] != b_q[N-1]) && (sl_d[W-1] != a_q[N-1]);
                    lt_d  = sl_d[W-1] ^ ovf_d;
                end
`endif
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
`ifdef SUB128_SERIAL_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            lt_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
`ifdef SUB128_SERIAL_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            lt_q     <= lt_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = borrow_q;

`ifdef SUB128_SERIAL_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
    assign lt_s = lt_q;
`endif

endmodule

// File: tb/tb_sub128_serial.sv
// Directed, table-driven bench for sub128_serial (flags checked when
// SUB128_SERIAL_FLAGS_EN is defined).
module tb_sub128_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] diff;
    logic         bout;
`ifdef SUB128_SERIAL_FLAGS_EN
    logic         zero, ovf, lt_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub128_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB128_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf),
        .lt_s      (lt_s)
`endif
    );

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         bin;
        logic [127:0] d;
        logic         bo;
        logic         z;
        logic         ov;
        logic         lt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Present operands for one edge, then count edges until out_valid (bounded).
    task automatic do_op(input logic [127:0] ta, input logic [127:0] tb_v, input logic tbin,
                         output int lat);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
        chk({tag, "_out_valid_after"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        int  lat;
        bit  saw;
        logic [127:0] held;

        vecs[0] = '{128'd100, 128'd42, 1'b0, 128'd58, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd1, 1'b0,
                    128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{128'd0, 128'd0, 1'b1, {128{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{128'd0, 128'd1, 1'b0, {128{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{{1'b0, {127{1'b1}}}, {128{1'b1}}, 1'b0, {1'b1, 127'd0}, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0,
                    128'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{{1'b1, 127'd0}, 128'd1, 1'b0, {1'b0, {127{1'b1}}}, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'd0, 1'b1,
                    128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{128'd5, 128'd5, 1'b1, {128{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #12;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_diff", diff, 128'd0);
        chk("reset_bout", 128'(bout), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'd4);
            chk($sformatf("v%0d_diff", i), diff, vecs[i].d);
            chk($sformatf("v%0d_bout", i), 128'(bout), 128'(vecs[i].bo));
            chk($sformatf("v%0d_in_ready_done", i), 128'(in_ready), 128'd0);
`ifdef SUB128_SERIAL_FLAGS_EN
            chk($sformatf("v%0d_zero", i), 128'(zero), 128'(vecs[i].z));
            chk($sformatf("v%0d_ovf", i), 128'(ovf), 128'(vecs[i].ov));
            chk($sformatf("v%0d_lt_s", i), 128'(lt_s), 128'(vecs[i].lt));
`endif
            release_result($sformatf("v%0d", i));
        end

        // Reset in the middle of RUN aborts with no output pulse.
        @(negedge clk);
        a = 128'd5; b = 128'd3; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_diff", diff, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("abort_no_pulse", 128'(saw), 128'd0);

        // Backpressure: result held, in_valid during DONE ignored.
        do_op(128'd100, 128'd42, 1'b0, lat);
        chk("bp_latency", 128'(lat), 128'd4);
        held = diff;
        chk("bp_diff_initial", held, 128'd58);
        for (int n = 0; n < 10; n++) begin
            in_valid = (n % 3 == 1);
            a        = 128'd7;
            b        = 128'd1;
            @(negedge clk);
            chk($sformatf("bp_hold_diff_%0d", n), diff, 128'd58);
            chk($sformatf("bp_hold_valid_%0d", n), 128'({out_valid, in_ready}), 128'b10);
        end
        in_valid = 1'b0;
        release_result("bp");
        saw = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid || !in_ready) saw = 1'b1;
        end
        chk("bp_no_ghost_op", 128'(saw), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
